// File: rtl/inst_pkg.sv
// Shared instruction-word layout: field positions, decoded field struct.
package inst_pkg;

  localparam int INST_LEN_DEF = 220;

  localparam int ILC_ST_ADDR_MSB   = 35;
  localparam int ILC_ST_ADDR_LSB   = 0;
  localparam int ILC_ISPAD_MSB     = 36;
  localparam int ILC_ISPAD_LSB     = 36;
  localparam int ILC_LINELEN_MSB   = 45;
  localparam int ILC_LINELEN_LSB   = 37;
  localparam int BSR_ISZERO_MSB    = 46;
  localparam int BSR_ISZERO_LSB    = 46;
  localparam int ILC_FROMFIFO_MSB  = 47;
  localparam int ILC_FROMFIFO_LSB  = 47;
  localparam int ILC_TOFIFO_MSB    = 48;
  localparam int ILC_TOFIFO_LSB    = 48;
  localparam int IS_W2C_BACK_MSB   = 49;
  localparam int IS_W2C_BACK_LSB   = 49;
  localparam int BSR_BUFFERMUX_MSB = 57;
  localparam int BSR_BUFFERMUX_LSB = 50;
  // Bits 60:58 are reserved.
  localparam int W2C_ST_ADDR_MSB   = 96;
  localparam int W2C_ST_ADDR_LSB   = 61;
  localparam int W2C_LINELEN_MSB   = 105;
  localparam int W2C_LINELEN_LSB   = 97;
  localparam int W2C_POOLED_MSB    = 106;
  localparam int W2C_POOLED_LSB    = 106;
  localparam int POOLED_TYPE_MSB   = 108;
  localparam int POOLED_TYPE_LSB   = 107;
  localparam int WB_ST_RD_ADDR_MSB = 116;
  localparam int WB_ST_RD_ADDR_LSB = 109;
  localparam int W2C_SHIFT_LEN_MSB = 121;
  localparam int W2C_SHIFT_LEN_LSB = 117;
  localparam int W2C_VALID_MAC_MSB = 123;
  localparam int W2C_VALID_MAC_LSB = 122;
  localparam int IS_BB_MSB         = 124;
  localparam int IS_BB_LSB         = 124;
  localparam int BIAS_ADDR_MSB     = 160;
  localparam int BIAS_ADDR_LSB     = 125;
  localparam int BIAS_SHIFT_MSB    = 165;
  localparam int BIAS_SHIFT_LSB    = 161;

  typedef struct packed {
    logic [4:0]  bias_shift;
    logic [35:0] bias_addr;
    logic        is_bb;
    logic [1:0]  w2c_valid_mac;
    logic [4:0]  w2c_shift_len;
    logic [7:0]  wb_st_rd_addr;
    logic [1:0]  pooled_type;
    logic        w2c_pooled;
    logic [8:0]  w2c_linelen;
    logic [35:0] w2c_st_addr;
    logic [7:0]  bsr_buffermux;
    logic        is_w2c_back;
    logic        ilc_tofifo;
    logic        ilc_fromfifo;
    logic        bsr_iszero;
    logic [8:0]  ilc_linelen;
    logic        ilc_ispad;
    logic [35:0] ilc_st_addr;
  } inst_t;

endpackage

// File: rtl/inst_fetch_issue_decode.sv
// Combinational slicing of a raw instruction word into its named fields.
module inst_field_decode
  import inst_pkg::*;
#(
  parameter int INST_LEN = INST_LEN_DEF
) (
  input  logic [INST_LEN-1:0] word_i,
  output inst_t               fields_o
);

  // Pure bit-field extraction; no qualification by valid.
  always_comb begin
    fields_o               = '0;
    fields_o.ilc_st_addr   = word_i[ILC_ST_ADDR_MSB:ILC_ST_ADDR_LSB];
    fields_o.ilc_ispad     = word_i[ILC_ISPAD_MSB];
    fields_o.ilc_linelen   = word_i[ILC_LINELEN_MSB:ILC_LINELEN_LSB];
    fields_o.bsr_iszero    = word_i[BSR_ISZERO_MSB];
    fields_o.ilc_fromfifo  = word_i[ILC_FROMFIFO_MSB];
    fields_o.ilc_tofifo    = word_i[ILC_TOFIFO_MSB];
    fields_o.is_w2c_back   = word_i[IS_W2C_BACK_MSB];
    fields_o.bsr_buffermux = word_i[BSR_BUFFERMUX_MSB:BSR_BUFFERMUX_LSB];
    fields_o.w2c_st_addr   = word_i[W2C_ST_ADDR_MSB:W2C_ST_ADDR_LSB];
    fields_o.w2c_linelen   = word_i[W2C_LINELEN_MSB:W2C_LINELEN_LSB];
    fields_o.w2c_pooled    = word_i[W2C_POOLED_MSB];
    fields_o.pooled_type   = word_i[POOLED_TYPE_MSB:POOLED_TYPE_LSB];
    fields_o.wb_st_rd_addr = word_i[WB_ST_RD_ADDR_MSB:WB_ST_RD_ADDR_LSB];
    fields_o.w2c_shift_len = word_i[W2C_SHIFT_LEN_MSB:W2C_SHIFT_LEN_LSB];
    fields_o.w2c_valid_mac = word_i[W2C_VALID_MAC_MSB:W2C_VALID_MAC_LSB];
    fields_o.is_bb         = word_i[IS_BB_MSB];
    fields_o.bias_addr     = word_i[BIAS_ADDR_MSB:BIAS_ADDR_LSB];
    fields_o.bias_shift    = word_i[BIAS_SHIFT_MSB:BIAS_SHIFT_LSB];
  end

endmodule

// File: rtl/inst_fetch_issue.sv
// Instruction fetch/issue: show-ahead FIFO consumer with PF/IS buffering,
// outstanding-work gate, barrier enforcement and issue counters.
module inst_fetch_issue
  import inst_pkg::*;
#(
  parameter int  INST_LEN        = INST_LEN_DEF,
  parameter int  MAX_OUTSTANDING = 4,
  parameter int  CNT_W           = 32,
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INST_LEN-1:0] instruct,
  input  logic                inst_empty,
  output logic                inst_req,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [INST_LEN-1:0] dec_inst,
  output logic [35:0]         ilc_st_addr,
  output logic [8:0]          ilc_linelen,
  output logic [7:0]          bsr_buffermux,
  output logic [35:0]         w2c_st_addr,
  output logic [8:0]          w2c_linelen,
  output logic [4:0]          w2c_shift_len,
  output logic                is_bb,
  input  logic                exec_done,
  output logic [OUT_W-1:0]    outstanding,
  output logic [CNT_W-1:0]    inst_count,
  output logic                idle,
  output logic                err_underflow
);

  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  logic                pf_valid_q, pf_valid_d;
  logic                is_valid_q, is_valid_d;
  logic [INST_LEN-1:0] pf_q, pf_d;
  logic [INST_LEN-1:0] is_q, is_d;
  logic [OUT_W-1:0]    out_q, out_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                fire, is_load, pf_load;
  inst_t               is_fields;

  inst_field_decode #(.INST_LEN(INST_LEN)) u_decode (
    .word_i   (is_q),
    .fields_o (is_fields)
  );

  // Issue gate and buffer-advance conditions; gate sees only the registered count.
  always_comb begin
    dec_valid = is_valid_q & (out_q < MAX_OUT) & (!is_fields.is_bb | (out_q == '0));
    fire      = dec_valid & dec_ready;
    is_load   = !is_valid_q | fire;
    pf_load   = !pf_valid_q | (is_load & pf_valid_q);
    // rst_n gates the pop so the FIFO never advances while both sides are held in reset.
    inst_req  = rst_n & !inst_empty & pf_load;
  end

  // PF/IS next state: IS takes PF when it frees up, PF refills from the FIFO head.
  always_comb begin
    pf_valid_d = pf_valid_q;
    pf_d       = pf_q;
    is_valid_d = is_valid_q;
    is_d       = is_q;
    if (is_load) begin
      is_d       = pf_q;
      is_valid_d = pf_valid_q;
    end
    if (inst_req) begin
      pf_d       = instruct;
      pf_valid_d = 1'b1;
    end else if (is_load) begin
      pf_valid_d = 1'b0;
    end
  end

  // Outstanding/issue counters and sticky underflow flag.
  always_comb begin
    out_d = out_q;
    err_d = err_q;
    cnt_d = cnt_q + CNT_W'(fire);
    case ({fire, exec_done})
      2'b10:   out_d = out_q + 1'b1;
      2'b01: begin
        if (out_q != '0) out_d = out_q - 1'b1;
        else             err_d = 1'b1;
      end
      default: out_d = out_q;
    endcase
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_valid_q <= 1'b0;
      is_valid_q <= 1'b0;
      pf_q       <= '0;
      is_q       <= '0;
      out_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      pf_valid_q <= pf_valid_d;
      is_valid_q <= is_valid_d;
      pf_q       <= pf_d;
      is_q       <= is_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign dec_inst      = is_q;
  assign ilc_st_addr   = is_fields.ilc_st_addr;
  assign ilc_linelen   = is_fields.ilc_linelen;
  assign bsr_buffermux = is_fields.bsr_buffermux;
  assign w2c_st_addr   = is_fields.w2c_st_addr;
  assign w2c_linelen   = is_fields.w2c_linelen;
  assign w2c_shift_len = is_fields.w2c_shift_len;
  assign is_bb         = is_fields.is_bb;
  assign outstanding   = out_q;
  assign inst_count    = cnt_q;
  assign err_underflow = err_q;
  assign idle          = inst_empty & !pf_valid_q & !is_valid_q & (out_q == '0);

endmodule
